grid_loader: RTL
================

GRID_LOADER -- requirements
Module: grid_loader

Interface
REQ-001 SHALL have parameter N, default 8, grid side length; N >= 3.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 104, clk cycles per UART bit (12 MHz / 115200); >= 8.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 20, idle bit-periods allowed between bytes inside a frame.
REQ-004 SHALL have parameter INIT, default all-zero, N*N-bit grid value driven after reset.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-007 uart_rx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-008 cells_0  output  N*N  initial grid for the game; bit index N*j+i is cell (i,j).
REQ-009 load  output  1  one-cycle pulse: cells_0 has just been updated with a new grid.
REQ-010 busy  output  1  high while a frame is in progress (header accepted, frame not yet ended).
REQ-011 err  output  1  one-cycle pulse on any frame or byte error.

Function
REQ-012 SHALL pass uart_rx through a 2-flop synchronizer before any use.
REQ-013 Byte receiver SHALL detect start on a synchronized high-to-low transition while idle.
REQ-014 SHALL re-sample at CLKS_PER_BIT/2 after the edge; if the line is high, SHALL discard the start as a glitch with no err pulse.
REQ-015 SHALL sample 8 data bits at CLKS_PER_BIT intervals from the mid-start point, LSB first.
REQ-016 SHALL sample the stop bit one CLKS_PER_BIT later; stop = 0 SHALL discard the byte, pulse err, and abort any frame in progress.
REQ-017 Frame format: header 0xA5, then P = ceil(N*N/8) payload bytes, then one checksum byte equal to the XOR of all payload bytes.
REQ-018 Payload byte k bit b SHALL map to grid bit 8k+b; bits with 8k+b >= N*N SHALL be ignored but SHALL be included in the checksum.
REQ-019 Frame FSM states: WAIT_HDR, PAYLOAD, CHECKSUM.
REQ-020 In WAIT_HDR, non-0xA5 bytes SHALL be dropped silently; 0xA5 SHALL move to PAYLOAD with byte count 0 and running XOR 0.
REQ-021 In PAYLOAD, each byte SHALL be written into a shadow register and XORed into the running checksum; after byte P-1 the FSM SHALL move to CHECKSUM.
REQ-022 In CHECKSUM, on a match SHALL copy shadow to cells_0 and assert load in the same clk cycle, one cycle after the stop-bit sample; on a mismatch SHALL leave cells_0 unchanged and pulse err; both cases return to WAIT_HDR.
REQ-023 cells_0 SHALL change only atomically on a successful frame; partial frames SHALL never be visible.
REQ-024 A 0xA5 byte arriving in PAYLOAD or CHECKSUM SHALL be treated as data, not as a resync.
REQ-025 In PAYLOAD or CHECKSUM, with no start bit for TIMEOUT_BITS*CLKS_PER_BIT cycles after the last stop sample, SHALL abort to WAIT_HDR, pulse err, and keep cells_0.
REQ-026 busy SHALL be high exactly while in PAYLOAD or CHECKSUM.
REQ-027 load and err SHALL never be asserted in the same cycle.

Reset
REQ-028 While rst = 0: cells_0 = INIT, load = 0, busy = 0, err = 0, FSM = WAIT_HDR, receiver idle, counters and shadow cleared.
REQ-029 Reset asserted mid-byte or mid-frame SHALL discard all partial data with no load or err pulse; reception SHALL resume on the first start edge after rst returns to 1.

Verification (N=8, CLKS_PER_BIT=16, TIMEOUT_BITS=20)
REQ-030 Reset check: rst=0 for 3 cycles, INIT=64'h0000001C00000000 -> cells_0=INIT, load=busy=err=0.
REQ-031 Good frame: A5, 01 02 04 08 10 20 40 80, FF -> exactly one load pulse, cells_0=64'h8040201008040201, err never asserted.
REQ-032 Bad checksum: A5, eight 00 bytes, 01 -> one err pulse, no load pulse, cells_0 unchanged.
REQ-033 Bytes 3C 11 then A5 + valid frame -> leading bytes ignored (busy stays 0 until A5), single load pulse.
REQ-034 A5 followed by 3 bytes, then 400 idle cycles -> err pulse after 320 idle cycles, busy falls, cells_0 unchanged.
REQ-035 Stop bit forced to 0 on payload byte 2 -> err pulse, abort to WAIT_HDR; a following valid frame loads normally.

Source files
------------

// File: rtl/grid_loader.sv
// grid_loader: receives a framed grid image over an 8N1 UART line and
// publishes it atomically on cells_0. Frame = 0xA5, P payload bytes, XOR checksum.
module grid_loader #(
    parameter int              N            = 8,
    parameter int              CLKS_PER_BIT = 104,
    parameter int              TIMEOUT_BITS = 20,
    parameter logic [N*N-1:0]  INIT         = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_rx,
    output logic [N*N-1:0]     cells_0,
    output logic               load,
    output logic               busy,
    output logic               err
);

    localparam int NN      = N * N;
    localparam int P       = (NN + 7) / 8;
    localparam int HALF    = CLKS_PER_BIT / 2;
    localparam int TMO_LIM = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int TMO_W   = $clog2(TMO_LIM + 1);
    localparam int BCNT_W  = $clog2(P + 1);

    localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0]  BIT_M1    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TMO_W-1:0]  TMO_M1    = TMO_W'(TMO_LIM - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(P - 1);
    localparam logic [7:0]        HDR       = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {WAIT_HDR, PAYLOAD, CHECKSUM} fr_state_t;

    // synchronizer and edge history
    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    // byte receiver
    rx_state_t         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    // frame tracker
    fr_state_t         fr_state_q, fr_state_d;
    logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]        xor_q, xor_d;
    logic [NN-1:0]     shadow_q, shadow_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    // outputs
    logic [NN-1:0]     cells_q, cells_d;
    logic              load_q, load_d;
    logic              err_q, err_d;

    logic              start_edge;
    logic              byte_done;
    logic              stop_bad;
    logic              timeout;

    assign start_edge = (rx_state_q == RX_IDLE) && rx_prev_q && !rx_sync_q;

    // State register: every flop in the block, cleared by the active-low sync reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            fr_state_q <= WAIT_HDR;
            byte_cnt_q <= '0;
            xor_q      <= '0;
            shadow_q   <= '0;
            tmo_q      <= '0;
            cells_q    <= INIT;
            load_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            fr_state_q <= fr_state_d;
            byte_cnt_q <= byte_cnt_d;
            xor_q      <= xor_d;
            shadow_q   <= shadow_d;
            tmo_q      <= tmo_d;
            cells_q    <= cells_d;
            load_q     <= load_d;
            err_q      <= err_d;
        end
    end

    // Byte receiver: mid-start check, 8 LSB-first data samples, stop sample
    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q + CNT_W'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (start_edge) rx_state_d = RX_START;
            end
            RX_START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    // a line already back high at mid-start was only a glitch
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_M1) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_M1) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    byte_done  = rx_sync_q;
                    stop_bad   = !rx_sync_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Frame next-state: header hunt, payload capture into shadow, inter-byte timeout
    always_comb begin
        fr_state_d = fr_state_q;
        byte_cnt_d = byte_cnt_q;
        xor_d      = xor_q;
        shadow_d   = shadow_q;
        tmo_d      = '0;
        timeout    = 1'b0;
        // idle time is measured only while a frame is open and the receiver is quiet
        if (fr_state_q != WAIT_HDR && rx_state_q == RX_IDLE && !start_edge) begin
            if (tmo_q == TMO_M1) timeout = 1'b1;
            else                 tmo_d   = tmo_q + TMO_W'(1);
        end
        if (stop_bad || timeout) begin
            fr_state_d = WAIT_HDR;
        end else if (byte_done) begin
            case (fr_state_q)
                WAIT_HDR: begin
                    if (shift_q == HDR) begin
                        fr_state_d = PAYLOAD;
                        byte_cnt_d = '0;
                        xor_d      = '0;
                    end
                end
                PAYLOAD: begin
                    xor_d = xor_q ^ shift_q;
                    // bits beyond the grid fall outside this loop but still feed the XOR
                    for (int i = 0; i < NN; i++) begin
                        if ((i / 8) == int'(byte_cnt_q)) shadow_d[i] = shift_q[i % 8];
                    end
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    if (byte_cnt_q == LAST_BYTE) fr_state_d = CHECKSUM;
                end
                CHECKSUM: fr_state_d = WAIT_HDR;
                default:  fr_state_d = WAIT_HDR;
            endcase
        end
    end

    // Outputs: commit shadow on a good checksum, flag stop, checksum and timeout errors
    always_comb begin
        cells_d = cells_q;
        load_d  = 1'b0;
        err_d   = 1'b0;
        if (stop_bad || timeout) begin
            err_d = 1'b1;
        end else if (byte_done && fr_state_q == CHECKSUM) begin
            if (shift_q == xor_q) begin
                cells_d = shadow_q;
                load_d  = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign cells_0 = cells_q;
    assign load    = load_q;
    assign err     = err_q;
    assign busy    = (fr_state_q != WAIT_HDR);

endmodule
